// File: rtl/flash_bus_bridge.sv
// flash_bus_bridge: 6809 bus front end for the SPI flash read controller (window decode, CE/READY
// handshake, MRDY stretch, read-data drive). Define READ_CACHE_EN to add a one-entry read cache.
module flash_bus_bridge #(
    parameter logic [15:0] WIN_BASE = 16'hF000,
    parameter logic [15:0] WIN_MASK = 16'hF000,
    parameter int unsigned ACK_WAIT = 4,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_E,
    input  logic [15:0] i_ADDRESS_BUS,
    input  logic        i_RW,
    input  logic [7:0]  i_FLASH_DATA,
    input  logic        i_FLASH_READY,
    output logic        o_SPI_CE,
    output logic        o_MRDY,
    output logic [7:0]  o_DATA,
    output logic        o_DATA_OE,
    output logic        o_TIMEOUT
);
    localparam int ACK_W = $clog2(ACK_WAIT + 1);
    localparam int BSY_W = $clog2(TIMEOUT + 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_WAIT);
    localparam logic [BSY_W-1:0] BSY_LAST = BSY_W'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, REQ, BUSY, DONE, HOLD} state_t;

    function automatic logic [ACK_W-1:0] sat_ack(input logic [ACK_W-1:0] v);
        return (v == {ACK_W{1'b1}}) ? v : v + ACK_W'(1);
    endfunction

    function automatic logic [BSY_W-1:0] sat_bsy(input logic [BSY_W-1:0] v);
        return (v == {BSY_W{1'b1}}) ? v : v + BSY_W'(1);
    endfunction

    logic             rst_n_p0, rst_n_p1, rst_n;
    logic             e_p0, e_p1, e_p2, e_rise, e_fall;
    logic             win, hit, cache_hit;
    logic [7:0]       rd_data;
    state_t           state, state_nxt;
    logic [ACK_W-1:0] ack_cnt, ack_nxt;
    logic [BSY_W-1:0] bsy_cnt, bsy_nxt;
    logic             abort, abort_nxt;
    logic             ce_nxt, mrdy_nxt, oe_nxt, to_nxt;
    logic [7:0]       data_nxt;

    // reset asserts asynchronously, releases on a clk edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_n_p0 <= 1'b0;
            rst_n_p1 <= 1'b0;
        end else begin
            rst_n_p0 <= 1'b1;
            rst_n_p1 <= rst_n_p0;
        end
    end
    assign rst_n = rst_n_p1;

    // E: two synchroniser flops, third flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_p0 <= 1'b0;
            e_p1 <= 1'b0;
            e_p2 <= 1'b0;
        end else begin
            e_p0 <= i_E;
            e_p1 <= e_p0;
            e_p2 <= e_p1;
        end
    end

    assign e_rise = e_p1 & ~e_p2;
    assign e_fall = ~e_p1 & e_p2;
    assign win    = ((i_ADDRESS_BUS & WIN_MASK) == (WIN_BASE & WIN_MASK));
    assign hit    = i_RW && win;

`ifdef READ_CACHE_EN
    logic        c_vld, src_cache;
    logic [15:0] c_addr, addr_p0;
    logic [7:0]  c_data;

    assign cache_hit = c_vld && (c_addr == i_ADDRESS_BUS);
    assign rd_data   = src_cache ? c_data : i_FLASH_DATA;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_vld     <= 1'b0;
            src_cache <= 1'b0;
        end else begin
            if (state == IDLE && e_rise && hit)
                src_cache <= cache_hit;
            // a window write or an aborted read leaves the entry untrustworthy
            if ((e_rise && !i_RW && win) || (state == DONE && abort))
                c_vld <= 1'b0;
            else if (state == DONE)
                c_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && e_rise)
            addr_p0 <= i_ADDRESS_BUS;
        if (state == DONE && !abort) begin
            c_addr <= addr_p0;
            c_data <= rd_data;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign rd_data   = i_FLASH_DATA;
`endif

    always_comb begin
        state_nxt = state;
        ce_nxt    = o_SPI_CE;
        mrdy_nxt  = o_MRDY;
        data_nxt  = o_DATA;
        oe_nxt    = o_DATA_OE;
        to_nxt    = o_TIMEOUT;
        ack_nxt   = ack_cnt;
        bsy_nxt   = bsy_cnt;
        abort_nxt = abort;
        case (state)
            IDLE: begin
                if (e_rise && hit) begin
                    mrdy_nxt  = 1'b0;
                    abort_nxt = 1'b0;
                    if (cache_hit) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = REQ;
                        ce_nxt    = 1'b1;
                        ack_nxt   = '0;
                        bsy_nxt   = '0;
                    end
                end
            end
            REQ: begin
                if (!i_FLASH_READY) begin
                    state_nxt = BUSY;
                end else begin
                    // READY never dropped: controller skipped a repeat address, data is held
                    ack_nxt = sat_ack(ack_cnt);
                    if (ack_nxt >= ACK_LAST)
                        state_nxt = DONE;
                end
            end
            BUSY: begin
                bsy_nxt = sat_bsy(bsy_cnt);
                if (i_FLASH_READY) begin
                    state_nxt = DONE;
                end else if (bsy_nxt >= BSY_LAST) begin
                    state_nxt = DONE;
                    abort_nxt = 1'b1;
                    to_nxt    = 1'b1;
                end
            end
            DONE: begin
                ce_nxt    = 1'b0;
                mrdy_nxt  = 1'b1;
                oe_nxt    = 1'b1;
                data_nxt  = abort ? 8'hFF : rd_data;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (e_fall) begin
                    oe_nxt    = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_SPI_CE  <= 1'b0;
            o_MRDY    <= 1'b1;
            o_DATA    <= 8'h00;
            o_DATA_OE <= 1'b0;
            o_TIMEOUT <= 1'b0;
            ack_cnt   <= '0;
            bsy_cnt   <= '0;
            abort     <= 1'b0;
        end else begin
            o_SPI_CE  <= ce_nxt;
            o_MRDY    <= mrdy_nxt;
            o_DATA    <= data_nxt;
            o_DATA_OE <= oe_nxt;
            o_TIMEOUT <= to_nxt;
            ack_cnt   <= ack_nxt;
            bsy_cnt   <= bsy_nxt;
            abort     <= abort_nxt;
        end
    end
endmodule

// File: tb/tb_flash_bus_bridge.sv
// Randomised bench for flash_bus_bridge: 6809 bus driver, flash controller model and a
// transaction-level reference model (cache model active when READ_CACHE_EN is defined).
module tb_flash_bus_bridge;
    localparam logic [15:0] WIN_BASE = 16'hF000;
    localparam logic [15:0] WIN_MASK = 16'hF000;
    localparam int          ACK_WAIT = 4;
    localparam int          TIMEOUT  = 255;
    localparam int M_NORM = 0;
    localparam int M_SKIP = 1;
    localparam int M_HANG = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_E;
    logic [15:0] i_ADDRESS_BUS;
    logic        i_RW;
    logic [7:0]  i_FLASH_DATA;
    logic        i_FLASH_READY;
    logic        o_SPI_CE, o_MRDY, o_DATA_OE, o_TIMEOUT;
    logic [7:0]  o_DATA;

    int          n_chk, n_fail;
    int          ctl_mode, ctl_d, ctl_b;
    logic [7:0]  ctl_data;
    logic [7:0]  m_held;
    logic        m_to;
`ifdef READ_CACHE_EN
    logic        m_cvld;
    logic [15:0] m_caddr;
    logic [7:0]  m_cdata;
`endif

    flash_bus_bridge #(
        .WIN_BASE(WIN_BASE), .WIN_MASK(WIN_MASK), .ACK_WAIT(ACK_WAIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .i_E(i_E), .i_ADDRESS_BUS(i_ADDRESS_BUS), .i_RW(i_RW),
        .i_FLASH_DATA(i_FLASH_DATA), .i_FLASH_READY(i_FLASH_READY), .o_SPI_CE(o_SPI_CE),
        .o_MRDY(o_MRDY), .o_DATA(o_DATA), .o_DATA_OE(o_DATA_OE), .o_TIMEOUT(o_TIMEOUT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Flash controller: drops READY ctl_d cycles into CE, raises it ctl_b cycles later with data.
    initial begin : flash_ctrl
        int age;
        i_FLASH_READY = 1'b1;
        i_FLASH_DATA  = 8'h00;
        age = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!o_SPI_CE) begin
                i_FLASH_READY = 1'b1;
                age = 0;
            end else begin
                age++;
                if (ctl_mode != M_SKIP && age == ctl_d)
                    i_FLASH_READY = 1'b0;
                if (ctl_mode == M_NORM && age == ctl_d + ctl_b) begin
                    i_FLASH_READY = 1'b1;
                    i_FLASH_DATA  = ctl_data;
                end
            end
        end
    end

    task automatic bus_cycle(input logic [15:0] addr, input logic rw,
                             output int lo, output int ce, output logic [7:0] dat,
                             output logic oe_hi, output logic oe_hold, output logic oe_end);
        int n;
        lo = 0;
        ce = 0;
        @(posedge clk);
        #1;
        i_ADDRESS_BUS = addr;
        i_RW = rw;
        i_E = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (o_SPI_CE) ce++;
            if (!o_MRDY) lo++;
        end
        @(posedge clk);
        #1;
        i_E = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (o_SPI_CE) ce++;
            if (!o_MRDY) lo++;
        end while ((n < 6 || !o_MRDY) && n < 600);
        if (n >= 600) chk("mrdy_release_bound", o_MRDY, 1'b1);
        dat   = o_DATA;
        oe_hi = o_DATA_OE;
        @(posedge clk);
        #1;
        i_E = 1'b0;
        @(negedge clk);
        oe_hold = o_DATA_OE;
        if (o_SPI_CE) ce++;
        repeat (5) begin
            @(negedge clk);
            if (o_SPI_CE) ce++;
        end
        oe_end = o_DATA_OE;
    endtask

    task automatic xact(input string nm, input logic [15:0] addr, input logic rw,
                        input int mode, input int d, input int b, input logic [7:0] dat_in);
        int         lo, ce, exp_lat, exp_ce;
        logic [7:0] dat, exp_dat;
        logic       oe_hi, oe_hold, oe_end, inwin, is_hit, from_cache, aborted;
        inwin      = ((addr & WIN_MASK) == (WIN_BASE & WIN_MASK));
        is_hit     = rw && inwin;
        from_cache = 1'b0;
        aborted    = 1'b0;
`ifdef READ_CACHE_EN
        from_cache = is_hit && m_cvld && (m_caddr == addr);
`endif
        ctl_mode = mode;
        ctl_d    = d;
        ctl_b    = b;
        ctl_data = dat_in;
        bus_cycle(addr, rw, lo, ce, dat, oe_hi, oe_hold, oe_end);
        exp_lat = 0;
        exp_dat = 8'h00;
        if (is_hit) begin
            if (from_cache) begin
                exp_lat = 1;
`ifdef READ_CACHE_EN
                exp_dat = m_cdata;
`endif
            end else if (mode == M_NORM) begin
                exp_lat = d + b + 1;
                exp_dat = dat_in;
                m_held  = dat_in;
            end else if (mode == M_SKIP) begin
                exp_lat = ACK_WAIT + 1;
                exp_dat = m_held;
            end else begin
                exp_lat = d + TIMEOUT + 1;
                exp_dat = 8'hFF;
                m_to    = 1'b1;
                aborted = 1'b1;
            end
        end
        exp_ce = from_cache ? 0 : exp_lat;
        chk($sformatf("%s_mrdy_low", nm), lo, exp_lat);
        chk($sformatf("%s_ce_high", nm), ce, exp_ce);
        chk($sformatf("%s_oe_at_mrdy", nm), oe_hi, is_hit);
        if (is_hit) begin
            chk($sformatf("%s_data", nm), dat, exp_dat);
            chk($sformatf("%s_oe_hold", nm), oe_hold, 1'b1);
        end
        chk($sformatf("%s_oe_end", nm), oe_end, 1'b0);
        chk($sformatf("%s_timeout", nm), o_TIMEOUT, m_to);
`ifdef READ_CACHE_EN
        if (!rw && inwin) m_cvld = 1'b0;
        else if (is_hit && aborted) m_cvld = 1'b0;
        else if (is_hit) begin
            m_cvld  = 1'b1;
            m_caddr = addr;
            m_cdata = exp_dat;
        end
`endif
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int         r, mode;
        logic [15:0] a;
        n_chk = 0;
        n_fail = 0;
        reset = 1'b0;
        i_E = 1'b0;
        i_ADDRESS_BUS = 16'h0000;
        i_RW = 1'b1;
        ctl_mode = M_NORM;
        ctl_d = 1;
        ctl_b = 1;
        ctl_data = 8'h00;
        m_held = 8'h00;
        m_to = 1'b0;
`ifdef READ_CACHE_EN
        m_cvld = 1'b0;
        m_caddr = 16'h0000;
        m_cdata = 8'h00;
`endif
        repeat (3) @(negedge clk);
        chk("rst_ce", o_SPI_CE, 1'b0);
        chk("rst_mrdy", o_MRDY, 1'b1);
        chk("rst_data", o_DATA, 8'h00);
        chk("rst_oe", o_DATA_OE, 1'b0);
        chk("rst_timeout", o_TIMEOUT, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);

        xact("rd_f123", 16'hF123, 1'b1, M_NORM, 2, 78, 8'h5A);
        xact("miss_8000", 16'h8000, 1'b1, M_NORM, 1, 5, 8'h00);
        xact("wr_f000", 16'hF000, 1'b0, M_NORM, 1, 5, 8'h00);
        xact("rd_f010_a", 16'hF010, 1'b1, M_NORM, 1, 5, 8'h3C);
        xact("rd_f010_b", 16'hF010, 1'b1, M_SKIP, 1, 1, 8'h00);
        xact("rd_edge_ack", 16'hF020, 1'b1, M_NORM, ACK_WAIT, 1, 8'hC3);
        xact("rd_short", 16'hFFFF, 1'b1, M_NORM, 1, 1, 8'h81);
        xact("rd_hang", 16'hF300, 1'b1, M_HANG, 1, 0, 8'h00);
        xact("rd_after_to", 16'hF301, 1'b1, M_NORM, 3, 7, 8'h96);

        // reset while the controller is busy
        ctl_mode = M_NORM;
        ctl_d = 1;
        ctl_b = 200;
        ctl_data = 8'h11;
        @(posedge clk);
        #1;
        i_ADDRESS_BUS = 16'hF400;
        i_RW = 1'b1;
        i_E = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        i_E = 1'b1;
        repeat (20) @(negedge clk);
        chk("busy_ce", o_SPI_CE, 1'b1);
        chk("busy_mrdy", o_MRDY, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_ce", o_SPI_CE, 1'b0);
        chk("midrst_mrdy", o_MRDY, 1'b1);
        chk("midrst_oe", o_DATA_OE, 1'b0);
        chk("midrst_timeout", o_TIMEOUT, 1'b0);
        m_to = 1'b0;
`ifdef READ_CACHE_EN
        m_cvld = 1'b0;
`endif
        @(posedge clk);
        #1;
        i_E = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        xact("rd_post_rst", 16'hF400, 1'b1, M_NORM, 2, 9, 8'h24);

`ifdef READ_CACHE_EN
        xact("c_fill", 16'hF200, 1'b1, M_NORM, 1, 6, 8'hA7);
        xact("c_hit", 16'hF200, 1'b1, M_NORM, 1, 6, 8'h55);
        xact("c_wr", 16'hF200, 1'b0, M_NORM, 1, 6, 8'h00);
        xact("c_refill", 16'hF200, 1'b1, M_NORM, 1, 6, 8'h66);
`endif

        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2) a = {1'b0, 15'($urandom)};
            else a = WIN_BASE + 16'($urandom_range(0, 3) * 16);
            mode = ($urandom_range(0, 3) == 0) ? M_SKIP : M_NORM;
            xact($sformatf("rnd%0d", i), a, ($urandom_range(0, 4) != 0), mode,
                 $urandom_range(1, ACK_WAIT), $urandom_range(1, 30), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
